// File: rtl/rgb_encoder.sv
// Thresholds a 24-bit RGB pixel into a 3-bit colour plus an exact flag.
// Results pass through a 2-entry output FIFO, and a saturating counter tracks inexact pixels.
//
// state | meaning
// EMPTY | no buffered entry, out_valid=0, head keeps the last value
// ONE   | head entry valid, tail free
// FULL  | head and tail valid, in_ready=0
module rgb_encoder #(
   parameter logic [7:0] THRESH = 8'h80
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [23:0] rgb_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [2:0]  colour,
   output logic        exact,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] inexact_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t        state_q, state_d;
   logic [3:0]  enc;
   logic [3:0]  head_q, head_d;
   logic [3:0]  tail_q, tail_d;
   logic        push, pop;
   logic [7:0]  ch_r, ch_g, ch_b;
   logic        ex_r, ex_g, ex_b;

   assign ch_r = rgb_in[23:16];
   assign ch_g = rgb_in[15:8];
   assign ch_b = rgb_in[7:0];

   assign ex_r = (ch_r == 8'h00) || (ch_r == 8'hFF);
   assign ex_g = (ch_g == 8'h00) || (ch_g == 8'hFF);
   assign ex_b = (ch_b == 8'h00) || (ch_b == 8'hFF);

   // Entry layout is {colour[2:0], exact}.
   assign enc = {(ch_r >= THRESH), (ch_g >= THRESH), (ch_b >= THRESH), (ex_r & ex_g & ex_b)};

   assign in_ready  = enable & ~rst & (state_q != FULL);
   assign push      = in_valid & in_ready;
   assign out_valid = (state_q != EMPTY);
   assign pop       = out_valid & out_ready;

   assign colour = head_q[3:1];
   assign exact  = head_q[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= EMPTY;
         head_q        <= 4'b0000;
         tail_q        <= 4'b0000;
         inexact_count <= 16'h0000;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         if (push && !enc[0] && (inexact_count != 16'hFFFF)) begin
            inexact_count <= inexact_count + 16'd1;
         end
      end
   end

   // Popping to EMPTY leaves head_q untouched so colour/exact hold their last value.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               head_d  = enc;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               head_d = enc;
            end else if (push) begin
               tail_d  = enc;
               state_d = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

endmodule

// File: tb/tb_rgb_encoder.sv
// Directed bench for rgb_encoder: the driver queues hand-computed results on acceptance,
// and a monitor on the falling edge compares them against each popped head entry.
module tb_rgb_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [23:0] rgb_in = 24'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  colour;
   logic        exact;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] inexact_count;

   logic [2:0]  exp_col = 3'b000;
   logic        exp_ex = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [3:0] sb_q[$];
   logic       prev_hold = 1'b0;
   logic [3:0] prev_head = 4'b0;

   rgb_encoder #(.THRESH(8'h80)) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .rgb_in(rgb_in),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .colour(colour),
      .exact(exact),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .inexact_count(inexact_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] rgb, input logic [2:0] c, input logic e);
      rgb_in   = rgb;
      exp_col  = c;
      exp_ex   = e;
      in_valid = 1'b1;
   endtask

   // Inputs only change 1 time unit after a rising edge, so the falling edge sees what the next edge will use.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold stable", 32'({out_valid, colour, exact}), 32'({1'b1, prev_head}));
         end
         prev_hold = out_valid && !out_ready;
         prev_head = {colour, exact};
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected output", 32'({colour, exact}), 32'hDEAD);
            end else begin
               chk("scoreboard head", 32'({colour, exact}), 32'(sb_q.pop_front()));
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back({exp_col, exp_ex});
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] c;
      int budget;

      // reset
      enable = 1'b1;
      repeat (2) step();
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst colour", 32'(colour), 0);
      chk("rst exact", 32'(exact), 0);
      chk("rst count", 32'(inexact_count), 0);
      chk("rst in_ready", 32'(in_ready), 0);

      // first pixel after reset, one-cycle latency
      rst = 1'b0;
      out_ready = 1'b1;
      send(24'h0000FF, 3'b001, 1'b1);
      #1;
      chk("in_ready after rst", 32'(in_ready), 1);
      step();
      chk("first out_valid", 32'(out_valid), 1);
      chk("first colour", 32'(colour), 1);
      chk("first exact", 32'(exact), 1);
      chk("first count", 32'(inexact_count), 0);

      // all eight pure colours back to back
      for (int i = 0; i < 8; i++) begin
         c = 3'(i);
         send({{8{c[2]}}, {8{c[1]}}, {8{c[0]}}}, c, 1'b1);
         step();
         chk("pure out_valid", 32'(out_valid), 1);
         chk("pure colour", 32'(colour), 32'(c));
         chk("pure exact", 32'(exact), 1);
      end
      in_valid = 1'b0;
      repeat (2) step();
      chk("empty out_valid", 32'(out_valid), 0);
      chk("retained colour", 32'(colour), 7);
      chk("retained exact", 32'(exact), 1);

      // threshold boundary: 7F below, 80 at, C3 above
      send(24'h7F80C3, 3'b011, 1'b0);
      step();
      in_valid = 1'b0;
      chk("thresh colour", 32'(colour), 3);
      chk("thresh exact", 32'(exact), 0);
      chk("thresh count", 32'(inexact_count), 1);
      step();

      // backpressure: fill both entries, third waits
      out_ready = 1'b0;
      send(24'hFF0000, 3'b100, 1'b1);
      step();
      chk("occ1 in_ready", 32'(in_ready), 1);
      send(24'h00FF00, 3'b010, 1'b1);
      step();
      chk("full in_ready", 32'(in_ready), 0);
      send(24'h0000FF, 3'b001, 1'b1);
      repeat (2) step();
      chk("full in_ready held", 32'(in_ready), 0);
      chk("full head colour", 32'(colour), 4);
      chk("full out_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      step();
      chk("after pop colour", 32'(colour), 2);
      chk("after pop in_ready", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      chk("push-pop colour", 32'(colour), 1);
      chk("push-pop out_valid", 32'(out_valid), 1);
      step();
      chk("drained out_valid", 32'(out_valid), 0);

      // enable=0 blocks acceptance but not draining
      out_ready = 1'b0;
      send(24'h00FFFF, 3'b011, 1'b1);
      step();
      enable = 1'b0;
      send(24'h123456, 3'b000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("disabled in_ready", 32'(in_ready), 0);
         chk("disabled out_valid", 32'(out_valid), 1);
         chk("disabled colour", 32'(colour), 3);
         chk("disabled count", 32'(inexact_count), 1);
      end
      out_ready = 1'b1;
      step();
      chk("disabled drain", 32'(out_valid), 0);
      in_valid = 1'b0;
      enable = 1'b1;

      // out_ready with nothing buffered
      repeat (3) step();
      chk("idle ready out_valid", 32'(out_valid), 0);
      chk("idle ready colour", 32'(colour), 3);

      // drive the counter to saturation
      for (int i = 0; i < 65533; i++) begin
         if (i[0]) send(24'h010101, 3'b000, 1'b0);
         else      send(24'h808080, 3'b111, 1'b0);
         step();
      end
      chk("count FFFE", 32'(inexact_count), 32'hFFFE);
      for (int i = 0; i < 3; i++) begin
         send(24'h40C020, 3'b010, 1'b0);
         step();
         chk("count saturated", 32'(inexact_count), 32'hFFFF);
      end

      // reset while streaming
      rst = 1'b1;
      step();
      chk("mid rst out_valid", 32'(out_valid), 0);
      chk("mid rst count", 32'(inexact_count), 0);
      chk("mid rst in_ready", 32'(in_ready), 0);
      chk("mid rst colour", 32'(colour), 0);
      rst = 1'b0;
      in_valid = 1'b0;
      step();
      chk("post rst out_valid", 32'(out_valid), 0);

      budget = 10;
      while (sb_q.size() != 0 && budget > 0) begin
         step();
         budget--;
      end
      chk("scoreboard empty", 32'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rgb_encoder.md
RGB_ENCODER -- requirements
Module: rgb_encoder

Interface
REQ-001 Parameter THRESH, default 8'h80: per-channel threshold, where a channel value >= THRESH maps to 1.
REQ-002 The block SHALL use one clock, clk; reset is synchronous and active-high, named rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 enable  input  1  permits acceptance of new pixels.
REQ-006 rgb_in  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
REQ-007 in_valid  input  1  rgb_in valid this cycle.
REQ-008 in_ready  output  1  block can accept a pixel this cycle.
REQ-009 colour  output  3  encoded colour {R,G,B} at the head of the output buffer.
REQ-010 exact  output  1  the head pixel had every channel equal to 8'h00 or 8'hFF.
REQ-011 out_valid  output  1  colour/exact hold a valid entry.
REQ-012 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-013 inexact_count  output  16  saturating count of accepted pixels with exact=0.

Function
REQ-014 A pixel SHALL be accepted on a rising clk edge when in_valid & in_ready, and is never accepted otherwise.
REQ-015 in_ready SHALL equal enable & !rst & (buffer occupancy < 2).
REQ-016 The encoding SHALL be colour[2]=(R>=THRESH), colour[1]=(G>=THRESH), colour[0]=(B>=THRESH); this is the inverse of the 3-bit colour to 24-bit rgb converter for pure colours (e.g. 24'hFF00FF -> 3'b101).
REQ-017 The output buffer SHALL be a 2-entry FIFO holding {colour, exact}; the head drives colour, exact and out_valid, and out_valid = (occupancy != 0).
REQ-018 Latency: a pixel accepted into an empty buffer SHALL appear with out_valid=1 in the cycle after the accepting edge, with no combinational path from rgb_in to colour.
REQ-019 The head SHALL be popped on an edge where out_valid & out_ready; colour/exact SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, with the new entry becoming head on the next cycle; at occupancy 2 no push occurs (in_ready=0); a pop at occupancy 2 raises in_ready in the following cycle.
REQ-021 Order SHALL be preserved, i.e. FIFO order with no drop and no duplication.
REQ-022 enable=0 SHALL block acceptance only, so buffered entries continue to drain normally.
REQ-023 out_ready asserted with out_valid=0 SHALL have no effect.
REQ-024 inexact_count SHALL increment by 1 on each accepting edge whose pixel is inexact, and SHALL saturate at 16'hFFFF without wrapping.
REQ-025 When out_valid=0, colour and exact SHALL retain their last values (3'b000 / 0 after reset).

Reset
REQ-026 With rst=1 at a rising edge: occupancy 0, out_valid=0, colour=3'b000, exact=0, inexact_count=0.
REQ-027 in_ready SHALL be 0 while rst=1.
REQ-028 Reset mid-operation SHALL discard all buffered entries and any pixel presented in that cycle.
REQ-029 The first acceptance after reset SHALL be possible on the first edge with rst=0.

Verification
REQ-030 Reset then enable=1, in_valid=1, rgb_in=24'h0000FF, out_ready=1 -> next cycle out_valid=1, colour=3'b001, exact=1, inexact_count=0.
REQ-031 Stream all 8 pure colours 24'h000000..24'hFFFFFF with out_ready=1 -> colours 000,001,...,111 in order, each one cycle after acceptance, exact=1 throughout.
REQ-032 rgb_in=24'h7F80C3 with THRESH=8'h80 -> colour=3'b011, exact=0, inexact_count increments to 1.
REQ-033 out_ready=0 and push 3 pixels (FF0000, 00FF00, 0000FF) -> in_ready=0 after 2 accepts; releasing out_ready -> 100, 010 drained, then 001 accepted and output; no loss.
REQ-034 enable=0 with in_valid=1 for 5 cycles -> in_ready=0, no acceptance, out_valid unchanged, inexact_count unchanged.
REQ-035 Force inexact_count to 16'hFFFE via 65534 inexact pixels, then push 3 more inexact -> count stays at 16'hFFFF; assert rst mid-stream -> out_valid=0, count=0 next cycle.
